// File: rtl/pipelined_csa_pkg.sv
// Shared defaults and elaboration helpers for the pipelined carry-select adder.
package pipelined_csa_pkg;

    localparam int CSA_DEF_WIDTH = 16;
    localparam int CSA_DEF_BLK   = 4;

    function automatic int csa_num_stages(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic bit csa_cfg_ok(input int width, input int blk);
        return (blk > 0) && (width >= blk) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/csa_slice.sv
// Combinational BLK-bit carry-select slice: two ripple sums (carry 0 and 1),
// one of which is picked by the incoming carry.
module csa_slice #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           c_in,
    output logic [BLK-1:0] s,
    output logic           c_out
);

    logic [BLK:0] sum0;
    logic [BLK:0] sum1;

    assign sum0       = {1'b0, a} + {1'b0, b};
    assign sum1       = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    assign {c_out, s} = c_in ? sum1 : sum0;

endmodule

// File: rtl/pipelined_csa.sv
// Pipelined carry-select adder/subtractor, one BLK-bit slice per stage, with
// valid/ready on both sides. Define PIPELINED_CSA_OVF_EN to add the ovf output.
module pipelined_csa
    import pipelined_csa_pkg::*;
#(
    parameter int WIDTH = CSA_DEF_WIDTH,
    parameter int BLK   = CSA_DEF_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CSA_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);

    localparam int NSTG = csa_num_stages(WIDTH, BLK);

    if (!csa_cfg_ok(WIDTH, BLK)) begin : g_cfg_err
        $error("pipelined_csa: WIDTH must be a positive multiple of BLK");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             adv;

    // Whole pipeline moves in lockstep; only a stalled, occupied output blocks it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub | cin;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO  = k * BLK;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]    opa_in;
        logic [REM-1:0]    opb_in;
        logic              c_in;
        logic              vld_in;
        logic [BLK-1:0]    s_blk;
        logic              c_blk;
        logic [LO+BLK-1:0] res_d;
        logic [LO+BLK-1:0] res_q;
        logic              vld_q;
        logic              c_q;

        if (k == 0) begin : g_src
            assign opa_in = a;
            assign opb_in = b_eff;
            assign c_in   = c_eff;
            assign vld_in = in_valid;
            assign res_d  = s_blk;
        end else begin : g_src
            assign opa_in = g_stg[k-1].g_fwd.opa_q;
            assign opb_in = g_stg[k-1].g_fwd.opb_q;
            assign c_in   = g_stg[k-1].c_q;
            assign vld_in = g_stg[k-1].vld_q;
            assign res_d  = {s_blk, g_stg[k-1].res_q};
        end

        csa_slice #(.BLK(BLK)) u_slice (
            .a    (opa_in[BLK-1:0]),
            .b    (opb_in[BLK-1:0]),
            .c_in (c_in),
            .s    (s_blk),
            .c_out(c_blk)
        );

        // NOTE: result/carry registers are reset and only load valid items, so
        // sum/co read 0 after reset and bubbles never disturb a held result.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                if (vld_in) begin
                    c_q   <= c_blk;
                    res_q <= res_d;
                end
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            logic [REM-BLK-1:0] opa_q;
            logic [REM-BLK-1:0] opb_q;

            // NOTE: skew operands are only consumed behind a set valid bit, so
            // they need no reset.
            always_ff @(posedge clk) begin
                if (adv && vld_in) begin
                    opa_q <= opa_in[REM-1:BLK];
                    opb_q <= opb_in[REM-1:BLK];
                end
            end
        end

`ifdef PIPELINED_CSA_OVF_EN
        if (k == NSTG - 1) begin : g_ovf
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ s at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && vld_in) begin
                    ovf_q <= opa_in[BLK-1] ^ opb_in[BLK-1] ^ s_blk[BLK-1] ^ c_blk;
                end
            end
        end
`endif
    end

    assign out_valid = g_stg[NSTG-1].vld_q;
    assign sum       = g_stg[NSTG-1].res_q;
    assign co        = g_stg[NSTG-1].c_q;
`ifdef PIPELINED_CSA_OVF_EN
    assign ovf       = g_stg[NSTG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_csa.sv
// Directed bench for pipelined_csa (WIDTH=16, BLK=4): vector table plus
// reset, backpressure and mid-flight reset sequences.
module tb_pipelined_csa;

    localparam int WIDTH = 16;
    localparam int NV    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef PIPELINED_CSA_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    pipelined_csa #(.WIDTH(16), .BLK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
`ifdef PIPELINED_CSA_OVF_EN
        .ovf      (ovf),
`endif
        .co       (co)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    vec_t tbl [NV];
    exp_t exp_q [$];
    exp_t cur_exp;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   n_emit  = 0;
    bit   lat_chk = 1'b0;
    bit   acc_last;
    int   idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // One clock: score outputs and record acceptance mid-cycle, then step past the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_emit++;
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("co", 32'(co), 32'(e.co));
`ifdef PIPELINED_CSA_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                if (lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd4);
            end
        end
        acc_last = in_valid && in_ready && !rst;
        if (acc_last) begin
            e         = cur_exp;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        if (rst) exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h0005, 16'h0004, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0};
        tbl[1]  = '{16'h0006, 16'h0001, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
        tbl[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4]  = '{16'h0007, 16'h0001, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0};
        tbl[5]  = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[8]  = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[10] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        cur_exp   = '{sum: 16'h0, co: 1'b0, ovf: 1'b0, acc_cyc: 0};
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h1111;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #1;

        // Reset held two cycles with operands offered: nothing may enter.
        repeat (2) begin
            tick();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_co", 32'(co), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            tick();
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
            check("post_rst_sum", 32'(sum), 32'd0);
            check("post_rst_co", 32'(co), 32'd0);
        end

        // Back-to-back vector table, no backpressure: fixed 4-cycle latency.
        lat_chk = 1'b1;
        for (int i = 0; i < NV; i++) begin
            a           = tbl[i].a;
            b           = tbl[i].b;
            cin         = tbl[i].cin;
            sub         = tbl[i].sub;
            in_valid    = 1'b1;
            cur_exp.sum = tbl[i].sum;
            cur_exp.co  = tbl[i].co;
            cur_exp.ovf = tbl[i].ovf;
            tick();
            check("table_accept", 32'(acc_last), 32'd1);
        end
        in_valid = 1'b0;
        drain(20);
        lat_chk = 1'b0;

        // Stream 1..8 with out_ready low in cycles 5-7.
        idx    = 1;
        n_emit = 0;
        b      = 16'h0;
        cin    = 1'b0;
        sub    = 1'b0;
        for (int j = 0; j < 40 && (idx <= 8 || exp_q.size() > 0); j++) begin
            in_valid    = (idx <= 8);
            a           = 16'(idx);
            cur_exp.sum = 16'(idx);
            cur_exp.co  = 1'b0;
            cur_exp.ovf = 1'b0;
            out_ready   = !(j >= 5 && j <= 7);
            #1;
            if (j >= 5 && j <= 7) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_sum_hold", 32'(sum), 32'd2);
            end
            tick();
            if (acc_last) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_emit_count", 32'(n_emit), 32'd8);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Three items in flight, then a one-cycle reset discards them.
        n_emit = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            a           = 16'(100 + i);
            cur_exp.sum = 16'(100 + i);
            tick();
        end
        rst = 1'b1;
        a   = 16'd50;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        rst         = 1'b0;
        a           = 16'd2;
        b           = 16'd3;
        cur_exp.sum = 16'd5;
        tick();
        check("midrst_accept", 32'(acc_last), 32'd1);
        in_valid = 1'b0;
        lat_chk  = 1'b1;
        drain(10);
        lat_chk = 1'b0;
        repeat (4) tick();
        check("midrst_emit_count", 32'(n_emit), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
